// File: rtl/wired_pkg_queue.sv
// wired_pkg_queue: decoupling queue between fetch/decode and backend dispatch.
// Takes up to two packages per cycle (valid/ready/mask), stores them in a
// circular buffer and presents up to two per cycle, oldest first.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   flush_i         drop all stored packages (and any same-cycle push/pop)
//   pkg_valid_i     frontend offers a pair; pkg_mask_i bit0 = older slot
//   pkg_ready_o     at least two entries free (from registered count only)
//   pkg_i           input pair, slot0 in the low PKG_WIDTH bits
//   pkg_valid_o     at least one package stored
//   pkg_mask_o      11 when >=2 stored, 01 when one, 00 when empty
//   pkg_ready_i     backend takes everything presented this cycle
//   pkg_o           output pair, slot0 is the oldest entry
//   stall_cnt_o     cycles with pkg_valid_i && !pkg_ready_o
//   empty_cnt_o     cycles with !pkg_valid_o && !flush_i
//
// Optional feature: define WIRED_PKG_QUEUE_PERF_EN to build the two saturating
// 32-bit performance counters; otherwise both ports are tied to 0.
module wired_pkg_queue #(
  parameter int PKG_WIDTH = 128,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   pkg_valid_i,
  output logic                   pkg_ready_o,
  input  logic [1:0]             pkg_mask_i,
  input  logic [2*PKG_WIDTH-1:0] pkg_i,
  output logic                   pkg_valid_o,
  input  logic                   pkg_ready_i,
  output logic [1:0]             pkg_mask_o,
  output logic [2*PKG_WIDTH-1:0] pkg_o,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            empty_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PKG_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_WIDTH-1:0] count;

  logic                 push, pop;
  logic [1:0]           n_push, n_pop;
  logic [PKG_WIDTH-1:0] slot0, slot1, wr0;

  assign slot0 = pkg_i[PKG_WIDTH-1:0];
  assign slot1 = pkg_i[2*PKG_WIDTH-1:PKG_WIDTH];

  // Ready only needs the registered count, so a pop never lends credit to a
  // push in the same cycle; this keeps the ready path short.
  assign pkg_ready_o = (CNT_WIDTH'(DEPTH) - count) >= CNT_WIDTH'(2);
  assign pkg_valid_o = (count != '0);
  assign pkg_mask_o  = {count >= CNT_WIDTH'(2), count != '0};
  assign pkg_o       = {mem[head + PTR_W'(1)], mem[head]};

  assign push   = pkg_valid_i & pkg_ready_o & ~flush_i;
  assign pop    = pkg_valid_o & pkg_ready_i & ~flush_i;
  assign n_push = push ? ({1'b0, pkg_mask_i[0]} + {1'b0, pkg_mask_i[1]}) : 2'd0;
  assign n_pop  = pop ? (pkg_mask_o[1] ? 2'd2 : 2'd1) : 2'd0;

  // Compaction: a lone slot1 package lands at tail just like a lone slot0.
  assign wr0 = pkg_mask_i[0] ? slot0 : slot1;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + CNT_WIDTH'(n_push) - CNT_WIDTH'(n_pop);
    end
  end

  // Entry storage carries no reset; contents are only observed once counted.
  always_ff @(posedge clk) begin
    if (push && (pkg_mask_i != 2'b00)) mem[tail] <= wr0;
    if (push && (pkg_mask_i == 2'b11)) mem[tail + PTR_W'(1)] <= slot1;
  end

`ifdef WIRED_PKG_QUEUE_PERF_EN
  logic [31:0] stall_cnt, empty_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      empty_cnt <= '0;
    end else begin
      if (pkg_valid_i && !pkg_ready_o && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (!pkg_valid_o && !flush_i && (empty_cnt != '1))
        empty_cnt <= empty_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign empty_cnt_o = empty_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign empty_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_wired_pkg_queue.sv
module tb_wired_pkg_queue;

  localparam int PW    = 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            pkg_valid_i;
  logic            pkg_ready_o;
  logic [1:0]      pkg_mask_i;
  logic [2*PW-1:0] pkg_i;
  logic            pkg_valid_o;
  logic            pkg_ready_i;
  logic [1:0]      pkg_mask_o;
  logic [2*PW-1:0] pkg_o;
  logic [31:0]     stall_cnt_o;
  logic [31:0]     empty_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: an ideal FIFO of packages plus the two event counts.
  logic [PW-1:0] mq[$];
  int unsigned   stall_m, empty_m;

  always #5 clk = ~clk;

  wired_pkg_queue #(.PKG_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .pkg_valid_i(pkg_valid_i), .pkg_ready_o(pkg_ready_o),
    .pkg_mask_i(pkg_mask_i), .pkg_i(pkg_i),
    .pkg_valid_o(pkg_valid_o), .pkg_ready_i(pkg_ready_i),
    .pkg_mask_o(pkg_mask_o), .pkg_o(pkg_o),
    .stall_cnt_o(stall_cnt_o), .empty_cnt_o(empty_cnt_o)
  );

  // Drive one cycle of stimulus, advance the reference, then settle past the edge.
  task automatic step(input logic v, input logic [1:0] m, input logic rdy,
                      input logic fl, input logic [PW-1:0] d0, input logic [PW-1:0] d1);
    bit room;
    int npop;
    pkg_valid_i = v; pkg_mask_i = m; pkg_i = {d1, d0}; pkg_ready_i = rdy; flush_i = fl;
    room = (DEPTH - mq.size()) >= 2;
    if (v && !room && stall_m != 32'hFFFF_FFFF) stall_m++;
    if (mq.size() == 0 && !fl && empty_m != 32'hFFFF_FFFF) empty_m++;
    if (fl) mq.delete();
    else begin
      npop = (rdy && mq.size() > 0) ? ((mq.size() >= 2) ? 2 : 1) : 0;
      for (int i = 0; i < npop; i++) void'(mq.pop_front());
      if (v && room) begin
        if (m[0]) mq.push_back(d0);
        if (m[1]) mq.push_back(d1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 0; pkg_valid_i = 0; pkg_mask_i = 0; pkg_i = '0; pkg_ready_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); stall_m = 0; empty_m = 0;
    n_cmp++; if (pkg_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", pkg_valid_o); end
    n_cmp++; if (pkg_mask_o !== 2'b00) begin n_bad++; $display("FAIL reset_mask got=%b exp=00", pkg_mask_o); end
    n_cmp++; if (pkg_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", pkg_ready_o); end
    n_cmp++; if (stall_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
    n_cmp++; if (empty_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_empty got=%0d exp=0", empty_cnt_o); end
  endtask

  task automatic test_single();
    logic [PW-1:0] a, b;
    a = $urandom; b = $urandom;
    step(1, 2'b01, 0, 0, a, $urandom);
    step(1, 2'b10, 0, 0, $urandom, b);
    n_cmp++; if (pkg_mask_o !== 2'b11) begin n_bad++; $display("FAIL single_mask got=%b exp=11", pkg_mask_o); end
    n_cmp++; if (pkg_o[PW-1:0] !== a) begin n_bad++; $display("FAIL single_slot0 got=%h exp=%h", pkg_o[PW-1:0], a); end
    n_cmp++; if (pkg_o[2*PW-1:PW] !== b) begin n_bad++; $display("FAIL single_slot1 got=%h exp=%h", pkg_o[2*PW-1:PW], b); end
    step(0, 2'b00, 1, 0, 0, 0);
    n_cmp++; if (pkg_valid_o !== 1'b0 || pkg_mask_o !== 2'b00) begin
      n_bad++; $display("FAIL single_drain got=%b/%b exp=0/00", pkg_valid_o, pkg_mask_o); end
  endtask

  task automatic test_fill();
    logic [PW-1:0] first;
    first = $urandom;
    step(1, 2'b11, 0, 0, first, $urandom);
    for (int i = 0; i < 3; i++) step(1, 2'b11, 0, 0, $urandom, $urandom);
    n_cmp++; if (pkg_ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_ready got=%b exp=0", pkg_ready_o); end
    step(1, 2'b11, 0, 0, $urandom, $urandom);
    n_cmp++; if (pkg_o[PW-1:0] !== first || mq.size() != DEPTH) begin
      n_bad++; $display("FAIL fill_reject slot0 got=%h exp=%h", pkg_o[PW-1:0], first); end
    step(0, 2'b00, 1, 0, 0, 0);
    n_cmp++; if (pkg_ready_o !== 1'b1) begin n_bad++; $display("FAIL fill_pop_ready got=%b exp=1", pkg_ready_o); end
    n_cmp++; if (pkg_o[PW-1:0] !== mq[0]) begin n_bad++; $display("FAIL fill_pop_slot0 got=%h exp=%h", pkg_o[PW-1:0], mq[0]); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pkg_o !== {mq[1], mq[0]}) begin n_bad++; $display("FAIL fill_drain got=%h exp=%h", pkg_o, {mq[1], mq[0]}); end
      step(0, 2'b00, 1, 0, 0, 0);
    end
    n_cmp++; if (pkg_valid_o !== 1'b0) begin n_bad++; $display("FAIL fill_empty got=%b exp=0", pkg_valid_o); end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] p [6];
    for (int i = 0; i < 3; i++) step(1, (i == 1) ? 2'b10 : 2'b01, 0, 0, $urandom, $urandom);
    step(0, 2'b00, 1, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);
    foreach (p[i]) p[i] = $urandom;
    for (int i = 0; i < 3; i++) step(1, 2'b11, 0, 0, p[2*i], p[2*i+1]);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pkg_o !== {p[2*i+1], p[2*i]} || pkg_mask_o !== 2'b11) begin
        n_bad++; $display("FAIL wrap_pair%0d got=%h/%b exp=%h/11", i, pkg_o, pkg_mask_o, {p[2*i+1], p[2*i]}); end
      step(0, 2'b00, 1, 0, 0, 0);
    end
    for (int c = 0; c < 1000; c++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 1), $urandom_range(0, 63) == 0,
           $urandom, $urandom);
      n_cmp++;
      if (pkg_valid_o !== (mq.size() != 0) ||
          pkg_mask_o !== {mq.size() >= 2, mq.size() != 0} ||
          pkg_ready_o !== ((DEPTH - mq.size()) >= 2) ||
          (mq.size() >= 1 && pkg_o[PW-1:0] !== mq[0]) ||
          (mq.size() >= 2 && pkg_o[2*PW-1:PW] !== mq[1])) begin
        n_bad++;
        $display("FAIL rand_c%0d got v=%b m=%b r=%b o=%h exp size=%0d head=%h", c, pkg_valid_o,
                 pkg_mask_o, pkg_ready_o, pkg_o, mq.size(), (mq.size() != 0) ? mq[0] : '0);
      end
    end
  endtask

  task automatic test_simul_flush();
    logic [PW-1:0] c, x, y;
    c = $urandom; x = $urandom; y = $urandom;
    step(0, 2'b00, 0, 1, 0, 0);
    step(1, 2'b11, 0, 0, $urandom, $urandom);
    step(1, 2'b01, 0, 0, c, $urandom);
    step(1, 2'b11, 1, 0, x, $urandom);
    n_cmp++; if (mq.size() != 3 || pkg_mask_o !== 2'b11 || pkg_o[PW-1:0] !== c || pkg_o[2*PW-1:PW] !== x) begin
      n_bad++; $display("FAIL simul_pushpop got=%h/%b exp=%h/11", pkg_o, pkg_mask_o, {x, c}); end
    step(1, 2'b11, 0, 1, y, y);
    n_cmp++; if (pkg_valid_o !== 1'b0 || pkg_mask_o !== 2'b00) begin
      n_bad++; $display("FAIL flush_clear got=%b/%b exp=0/00", pkg_valid_o, pkg_mask_o); end
    step(0, 2'b00, 1, 0, 0, 0);
    n_cmp++; if (pkg_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_drop got=%b exp=0", pkg_valid_o); end
  endtask

  task automatic test_perf();
    int unsigned base, exp_stall, exp_empty;
    step(0, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'b11, 0, 0, $urandom, $urandom);
    base = stall_m;
    for (int i = 0; i < 5; i++) step(1, 2'b11, 0, 0, $urandom, $urandom);
`ifdef WIRED_PKG_QUEUE_PERF_EN
    exp_stall = stall_m; exp_empty = empty_m;
    n_cmp++; if (stall_m - base != 5) begin n_bad++; $display("FAIL perf_model_delta got=%0d exp=5", stall_m - base); end
`else
    exp_stall = 0; exp_empty = 0;
`endif
    n_cmp++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
    n_cmp++; if (empty_cnt_o !== exp_empty) begin n_bad++; $display("FAIL perf_empty got=%0d exp=%0d", empty_cnt_o, exp_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simul_flush();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wired_pkg_queue.md
Name: wired_pkg_queue

Overview:
- Decoupling queue between the fetch/decode frontend and the backend dispatch.
- Accepts up to two pipeline control packages per cycle from the frontend, using a valid/ready/mask handshake.
- Buffers them in a circular store and presents up to two packages per cycle to the backend, in program order.
- Flushed on redirect: branch mispredict, exception or refetch.

Parameters:
- PKG_WIDTH, 128, bit width of one pipeline control package (sized to the packed package type at instantiation).
- DEPTH, 8, number of package entries; power of two, minimum 4.
- CNT_WIDTH, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- flush_i  input  1  discard all stored packages this cycle
- pkg_valid_i  input  1  frontend offers a package pair
- pkg_ready_o  output  1  queue can take a full pair this cycle
- pkg_mask_i  input  2  per-slot valid for the input pair; bit0 = older slot
- pkg_i  input  2*PKG_WIDTH  input pair; slot0 in bits [PKG_WIDTH-1:0]
- pkg_valid_o  output  1  at least one package is available to the backend
- pkg_ready_i  input  1  backend takes the presented packages
- pkg_mask_o  output  2  per-slot valid for the output pair
- pkg_o  output  2*PKG_WIDTH  output pair; slot0 is the oldest entry
- stall_cnt_o  output  32  cycles with pkg_valid_i=1 and pkg_ready_o=0 (optional feature)
- empty_cnt_o  output  32  cycles with pkg_valid_o=0 and flush_i=0 (optional feature)

Behaviour:
- Storage:
  - DEPTH x PKG_WIDTH entry array, registered.
  - head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register of CNT_WIDTH bits.
- Reset: head=0, tail=0, count=0, both perf counters=0. Entry contents are don't-care.
- Outputs after reset: pkg_valid_o=0, pkg_mask_o=2'b00, pkg_ready_o=1.
- pkg_ready_o = (DEPTH - count >= 2), computed from the registered count only. No same-cycle credit from a pop.
- Push occurs when pkg_valid_i && pkg_ready_o && !flush_i:
  - Valid slots are compacted and written in order starting at tail.
  - mask 2'b01 or 2'b10: one entry written at tail, with the valid slot's data.
  - mask 2'b11: slot0 written at tail, slot1 at tail+1.
  - mask 2'b00: handshake completes, nothing is stored.
  - tail and count advance by popcount(mask).
- Output is combinational from registered state, with no input-to-output bypass:
  - pkg_valid_o = (count != 0).
  - pkg_mask_o = 2'b11 if count>=2; 2'b01 if count==1; 2'b00 if count==0.
  - pkg_o slot0 = entry[head]; slot1 = entry[head+1] (wrapped).
  - slot1 data is don't-care when mask bit1=0.
- Pop occurs when pkg_valid_o && pkg_ready_i && !flush_i. head advances by popcount(pkg_mask_o) and count decreases by the same amount.
- Simultaneous push and pop:
  - Both apply in the same cycle.
  - count_next = count + pushed - popped. Never overflows, because push requires 2 free entries.
- Latency: a package pushed in cycle N is visible on pkg_o in cycle N+1 at the earliest.
- Flush:
  - flush_i=1 sets head=tail=0 and count=0 next cycle.
  - Overrides any push or pop in the same cycle; the input pair is dropped even if pkg_ready_o=1.
  - Outputs are not masked during the flush cycle itself. The backend ignores them under its own flush.
- Wrap-around: writes and reads at index DEPTH-1 continue at index 0. A pair straddling the boundary splits across DEPTH-1 and 0.
- Full: with count=DEPTH-1, pkg_ready_o=0 even though one entry is free.
- Reset asserted mid-operation: same as flush plus perf counter clear. Takes effect on the next edge.

Optional Feature:
- Macro: WIRED_PKG_QUEUE_PERF_EN.
- With the macro:
  - stall_cnt_o increments each cycle with pkg_valid_i && !pkg_ready_o.
  - empty_cnt_o increments each cycle with !pkg_valid_o && !flush_i.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF and clear only on rst.
- Without the macro:
  - Both ports remain and are driven constant 0.
  - No counter registers are synthesized.

Test Plan:
- Reset: after rst high, pkg_valid_o=0, pkg_mask_o=00, pkg_ready_o=1, count=0.
- Single pushes: push mask 01 data A, then mask 10 data B with pkg_ready_i=0 -> count=2, pkg_mask_o=11, slot0=A, slot1=B; pkg_ready_i=1 for one cycle -> count=0.
- Fill with DEPTH=8:
  - Push four pairs (mask 11) with pkg_ready_i=0 -> pkg_ready_o=0 after the 4th.
  - A further pkg_valid_i is not accepted.
  - Pop once -> count=6, pkg_ready_o=1.
- Wrap:
  - Push 3 singles, pop 3, then push pairs until tail wraps.
  - Pair at indices 7 and 0 is read back in order.
  - Output sequence matches an ideal reference queue for 1000 random-mask, random-ready cycles.
- Simultaneous push/pop plus flush:
  - With count=3: push 11 and pop 11 in the same cycle -> count=3.
  - Next cycle: flush_i=1 together with push 11 -> count=0, pkg_valid_o=0; the flushed-cycle pair never appears.
- Perf (macro defined): hold the queue full with pkg_valid_i=1 for 5 cycles -> stall_cnt_o=5. Without the macro, stall_cnt_o=0 throughout.
